// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared constants and helpers for the push-button conditioning block.
//   NUM_BTN        : number of board button channels (BTN[4:0])
//   DEBOUNCE_20MS  : stability window at 50 MHz
//   REPEAT_500MS   : hold time before the first auto-repeat strobe at 50 MHz
//   REPEAT_100MS   : spacing of subsequent auto-repeat strobes at 50 MHz
// ---------------------------------------------------------------------------
package btn_pkg;

  localparam int unsigned NUM_BTN       = 5;
  localparam int unsigned DEBOUNCE_20MS = 1_000_000;
  localparam int unsigned REPEAT_500MS  = 25_000_000;
  localparam int unsigned REPEAT_100MS  = 5_000_000;

  // Auto-repeat phase: waiting for the initial delay, or repeating periodically.
  typedef enum logic {
    REP_FIRST    = 1'b0,
    REP_PERIODIC = 1'b1
  } rep_phase_e;

  // Width of a counter that must hold the values 0 .. n-1 (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// ---------------------------------------------------------------------------
// btn_debounce_chan
// One button channel: 2-flop synchroniser, stability-count filter, registered
// press/release strobes and (optionally) auto-repeat press strobes.
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn         : raw, bouncing button pin
//   level       : debounced button level
//   press_stb   : one-cycle strobe on accepted press (and on each auto-repeat)
//   release_stb : one-cycle strobe on accepted release
// ---------------------------------------------------------------------------
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press_stb,
  output logic release_stb
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce_chan: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;
  logic          accept;   // level changes on this edge
  logic          rise;     // accepted 0->1 transition

  // Synchroniser: the filter only ever looks at s1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn;
      s1 <= s0;
    end
  end

  assign accept = (s1 != level) && (cnt == CNT_LAST);
  assign rise   = accept && s1;

  // Stability filter: any sample agreeing with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s1 == level) begin
      cnt <= '0;
    end else if (accept) begin
      level <= s1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned   RW         = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

  rep_phase_e    phase;
  logic [RW-1:0] rcnt;
  logic          rep_fire;

  // With level high, accept can only mean level is falling: no repeat on that edge.
  assign rep_fire = level && !accept &&
                    (rcnt == ((phase == REP_FIRST) ? DELAY_LAST : PER_LAST));

  // Repeat counter runs only while the debounced level is high; the edge that
  // raises level sees level=0 here, so counting starts from 0 at the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= REP_FIRST;
      rcnt  <= '0;
    end else if (!level || accept) begin
      phase <= REP_FIRST;
      rcnt  <= '0;
    end else if (rep_fire) begin
      phase <= REP_PERIODIC;
      rcnt  <= '0;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end
`else
  logic rep_fire;
  assign rep_fire = 1'b0;
`endif

  // Strobes are registered on the same edge that updates level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      press_stb   <= rise || rep_fire;
      release_stb <= accept && !s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions the raw board push-buttons: per-channel synchronise, debounce and
// generate one-cycle press/release strobes for the timer/memory datapath.
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN (auto-repeat press strobes)
//   CLK         : system clock, rising edge
//   RST_N       : asynchronous active-low reset
//   BTN         : raw button pins [NUM_BTN-1:0]
//   BTN_LEVEL   : debounced levels
//   BTN_PRESS   : one-cycle press strobes (plus auto-repeat when enabled)
//   BTN_RELEASE : one-cycle release strobes
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = btn_pkg::NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_20MS,
  parameter int unsigned REPEAT_DELAY    = btn_pkg::REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = btn_pkg::REPEAT_100MS
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk         (CLK),
      .rst_n       (RST_N),
      .btn         (BTN[i]),
      .level       (BTN_LEVEL[i]),
      .press_stb   (BTN_PRESS[i]),
      .release_stb (BTN_RELEASE[i])
    );
  end

endmodule
